lenet5_image_feeder: RTL and testbench
======================================

# lenet5_image_feeder

Upstream input stage of the LeNet-5 accelerator. It accepts pixels over a valid/ready load port into a two-bank (ping-pong) image buffer and streams each complete image into the network's `ce`/`i_fmap` inputs as one contiguous burst. It then waits for the network's classification end, pulses the network's `rst_processEnd`, and reports the classification result. Loading of image N+1 overlaps processing of image N.

## Interface
- `I_SIZE`, default 28: image side length; one image is N = I_SIZE*I_SIZE pixels.
- `I_BW`, default 8: pixel bit width; must equal the network's `I_BW1`.
- `TIMEOUT`, default 65535: maximum cycles spent in WAIT before a forced flush.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `global_rst`, input, 1: asynchronous, active-high reset.
- `i_pix_valid`, input, 1: load-port pixel valid.
- `i_pix_data`, input, I_BW: load-port pixel, signed, raster order.
- `o_pix_ready`, output, 1: load port can accept a pixel.
- `o_ce`, output, 1: network clock enable / pixel strobe.
- `o_fmap`, output, I_BW: pixel to the network's `i_fmap`.
- `o_rst_processEnd`, output, 1: one-cycle pulse that clears the network's per-image state.
- `i_cls_en`, input, 1: network `o_classification_en`.
- `i_cls_result`, input, 4: network `o_classification_result`.
- `i_cls_end`, input, 1: network `o_classification_end`.
- `o_result`, output, 4: last captured classification.
- `o_result_valid`, output, 1: one-cycle pulse; `o_result` is valid while it is high.
- `o_timeout`, output, 1: one-cycle pulse when WAIT expires.
- `o_busy`, output, 1: read FSM is not in IDLE.
- `o_img_count`, output, 16: number of images completed, including timeouts; wraps at 65535 to 0.

## Operation
- **Storage**
  - Two banks of N x I_BW synchronous-read RAM, with a `full[1:0]` flag per bank.
  - Write side owns `wr_bank` and `wr_addr`; read side owns `rd_bank` and `rd_addr`.
- **Load side**
  - `o_pix_ready = !full[wr_bank]`; this is combinational from registers.
  - A pixel is accepted when `i_pix_valid && o_pix_ready`. The write goes to `bank[wr_bank][wr_addr]` and `wr_addr` increments.
  - Accepting pixel N-1 sets `full[wr_bank]`, clears `wr_addr` to 0, and toggles `wr_bank`.
- **Read FSM: IDLE -> STREAM -> WAIT -> FLUSH -> IDLE**
  - IDLE: when `full[rd_bank]` is set, go to STREAM with `rd_addr` = 0.
  - STREAM: issue read address `rd_addr` every cycle. After address N-1 is issued, go to WAIT.
  - WAIT: the watchdog counter increments each cycle. Leave to FLUSH on `i_cls_end`, or when the counter reaches TIMEOUT (in that case pulse `o_timeout`).
  - FLUSH, one cycle:
    - pulse `o_rst_processEnd`;
    - clear `full[rd_bank]` and toggle `rd_bank`;
    - increment `o_img_count`;
    - go to IDLE.
- **Result capture**
  - On any cycle with `i_cls_en`, latch `i_cls_result` into `o_result`.
  - On `i_cls_end` in WAIT, pulse `o_result_valid` the next cycle.
  - If `i_cls_en` and `i_cls_end` are asserted in the same cycle, the value latched that cycle is the one reported.
  - `i_cls_end` outside WAIT is ignored.
- **Boundary conditions**
  - Both banks full: `o_pix_ready` is 0 until FLUSH.
  - Write completion and FLUSH in the same cycle on different banks: both flag updates apply.
  - FLUSH frees the bank the writer is stalled on: `o_pix_ready` rises the next cycle.
  - A bank is never written while it is full, so the read and write sides never collide.

## Timing
- **Reset values:**
  - `o_pix_ready` = 1;
  - `o_ce`, `o_fmap`, `o_rst_processEnd`, `o_result`, `o_result_valid`, `o_timeout`, `o_busy`, `o_img_count` = 0;
  - both `full` flags = 0, `wr_bank` = `rd_bank` = 0;
  - FSM = IDLE.
- **Reset mid-operation:** all state clears, partial or loaded images are discarded, and `o_ce` drops in the same cycle (asynchronously).
- **RAM read latency** is 1 cycle. `o_ce` and `o_fmap` are registered together, so the pixel at address k appears with `o_ce` = 1 one cycle after address k is issued.
- **Burst shape:** `o_ce` is high for exactly N consecutive cycles per image, with no gaps. `o_fmap` holds its last value when `o_ce` = 0.
- **Load-to-burst latency:** the last load pixel is accepted at cycle t. FSM = STREAM at t+2 (flag set at t+1, IDLE sees it at t+1). The first `o_ce` is at t+3.
- **End of image:** `i_cls_end` sampled at cycle t causes `o_rst_processEnd` = 1 and `o_result_valid` = 1 at t+1. The next burst's first `o_ce` is no earlier than t+4.
- **Throughput:** a continuous load stream at 1 pixel/cycle sustains back-to-back images limited only by network latency.
- **`o_busy`** = 1 from STREAM entry through the FLUSH cycle.

## Test plan
- **Single image:** reset, load 784 pixels 0..783 (mod 256) at full rate, network model returns `i_cls_en` + `i_cls_end` with result 7 after 100 cycles → `o_ce` high for exactly 784 cycles; `o_fmap` sequence matches the load; one `o_rst_processEnd` pulse; `o_result` = 7 with a `o_result_valid` pulse; `o_img_count` = 1.
- **Ping-pong backpressure:** load 3 images back-to-back, network delays `i_cls_end` by 2000 cycles → `o_pix_ready` drops after pixel 1568 and rises one cycle after the first FLUSH; 3 results arrive in order, `o_img_count` = 3.
- **Load throttling:** random `i_pix_valid` at 30 % duty → the burst still has 784 contiguous `o_ce` cycles and starts 3 cycles after the last accepted pixel.
- **Timeout:** TIMEOUT = 50, network never asserts `i_cls_end` → `o_timeout` pulses 50 cycles after WAIT entry, `o_rst_processEnd` pulses, no `o_result_valid`, `o_img_count` = 1.
- **Reset mid-burst:** assert `global_rst` at burst pixel 300 → `o_ce` = 0 immediately; after release `o_pix_ready` = 1 and both banks are empty; a fresh image then runs normally.
- **Stray end:** `i_cls_end` pulsed while in IDLE → no FLUSH, no `o_result_valid`, count unchanged.

Source files
------------

// File: rtl/lenet5_image_feeder.sv
// Ping-pong image buffer in front of the LeNet-5 core: loads pixels, bursts each
// full image into ce/i_fmap, then waits for the classification and reports it.
//
// state  | meaning
// IDLE   | waiting for the read bank to be full
// STREAM | issuing read addresses 0..N-1, one per cycle
// WAIT   | burst done, waiting for i_cls_end or the watchdog
// FLUSH  | one cycle: clear network state, release bank, count image
module lenet5_image_feeder #(
    parameter int I_SIZE  = 28,
    parameter int I_BW    = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic            clk,
    input  logic            global_rst,
    input  logic            i_pix_valid,
    input  logic [I_BW-1:0] i_pix_data,
    output logic            o_pix_ready,
    output logic            o_ce,
    output logic [I_BW-1:0] o_fmap,
    output logic            o_rst_processEnd,
    input  logic            i_cls_en,
    input  logic [3:0]      i_cls_result,
    input  logic            i_cls_end,
    output logic [3:0]      o_result,
    output logic            o_result_valid,
    output logic            o_timeout,
    output logic            o_busy,
    output logic [15:0]     o_img_count
);
    localparam int N  = I_SIZE * I_SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [WW-1:0] WD_LOAD   = WW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_FLUSH} state_t;

    state_t          state;
    state_t          state_nx;
    logic [I_BW-1:0] bank0 [N];
    logic [I_BW-1:0] bank1 [N];
    logic [1:0]      full;
    logic            wr_bank;
    logic            rd_bank;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [WW-1:0]   wd_cnt;
    logic            wd_tc;
    logic            pix_accept;
    logic            wr_done;
    logic            flush;

    assign o_pix_ready = !full[wr_bank];
    assign pix_accept  = i_pix_valid && o_pix_ready;
    assign wr_done     = pix_accept && (wr_addr == LAST_ADDR);
    assign wd_tc       = (wd_cnt == '0);

    // Image storage; a full bank is never written, so no read/write collision.
    always_ff @(posedge clk) begin
        if (pix_accept) begin
            if (wr_bank)
                bank1[wr_addr] <= i_pix_data;
            else
                bank0[wr_addr] <= i_pix_data;
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            wr_addr <= '0;
            wr_bank <= 1'b0;
        end else if (pix_accept) begin
            if (wr_done) begin
                wr_addr <= '0;
                wr_bank <= !wr_bank;
            end else begin
                wr_addr <= wr_addr + AW'(1);
            end
        end
    end

    // Set and clear always target different banks, so both can apply together.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            full <= 2'b00;
        end else begin
            if (wr_done && !wr_bank)
                full[0] <= 1'b1;
            else if (flush && !rd_bank)
                full[0] <= 1'b0;
            if (wr_done && wr_bank)
                full[1] <= 1'b1;
            else if (flush && rd_bank)
                full[1] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        flush            = 1'b0;
        o_timeout        = 1'b0;
        o_rst_processEnd = 1'b0;
        o_busy           = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (full[rd_bank])
                    state_nx = S_STREAM;
            end
            S_STREAM: begin
                if (rd_addr == LAST_ADDR)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (i_cls_end) begin
                    state_nx = S_FLUSH;
                end else if (wd_tc) begin
                    o_timeout = 1'b1;
                    state_nx  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush            = 1'b1;
                o_rst_processEnd = 1'b1;
                state_nx         = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Watchdog counts down from TIMEOUT across WAIT; reloaded everywhere else.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            rd_addr     <= '0;
            rd_bank     <= 1'b0;
            wd_cnt      <= WD_LOAD;
            o_img_count <= '0;
        end else begin
            if (state == S_STREAM && rd_addr != LAST_ADDR)
                rd_addr <= rd_addr + AW'(1);
            else
                rd_addr <= '0;
            if (state == S_WAIT) begin
                if (!wd_tc)
                    wd_cnt <= wd_cnt - WW'(1);
            end else begin
                wd_cnt <= WD_LOAD;
            end
            if (flush) begin
                rd_bank     <= !rd_bank;
                o_img_count <= o_img_count + 16'd1;
            end
        end
    end

    // RAM read register doubles as the o_fmap output register, aligned with o_ce.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            o_ce   <= 1'b0;
            o_fmap <= '0;
        end else begin
            o_ce <= (state == S_STREAM);
            if (state == S_STREAM)
                o_fmap <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            o_result       <= 4'd0;
            o_result_valid <= 1'b0;
        end else begin
            if (i_cls_en)
                o_result <= i_cls_result;
            o_result_valid <= (state == S_WAIT) && i_cls_end;
        end
    end

endmodule

// File: tb/tb_lenet5_image_feeder.sv
// Directed bench for lenet5_image_feeder: single image, ping-pong backpressure,
// throttled load, watchdog timeout, reset mid-burst and stray classification end.
module tb_lenet5_image_feeder;
    localparam int N = 784;

    logic        clk = 1'b0;
    logic        global_rst;
    logic        i_pix_valid;
    logic [7:0]  i_pix_data;
    logic        o_pix_ready;
    logic        o_ce;
    logic [7:0]  o_fmap;
    logic        o_rst_processEnd;
    logic        i_cls_en;
    logic [3:0]  i_cls_result;
    logic        i_cls_end;
    logic [3:0]  o_result;
    logic        o_result_valid;
    logic        o_timeout;
    logic        o_busy;
    logic [15:0] o_img_count;

    logic        t_valid;
    logic [7:0]  t_data;
    logic        t_ready;
    logic        t_ce;
    logic [7:0]  t_fmap;
    logic        t_rpe;
    logic        t_cls_en;
    logic [3:0]  t_cls_result;
    logic        t_cls_end;
    logic [3:0]  t_result;
    logic        t_rv;
    logic        t_to;
    logic        t_busy;
    logic [15:0] t_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lenet5_image_feeder dut (
        .clk(clk), .global_rst(global_rst),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
        .o_ce(o_ce), .o_fmap(o_fmap), .o_rst_processEnd(o_rst_processEnd),
        .i_cls_en(i_cls_en), .i_cls_result(i_cls_result), .i_cls_end(i_cls_end),
        .o_result(o_result), .o_result_valid(o_result_valid), .o_timeout(o_timeout),
        .o_busy(o_busy), .o_img_count(o_img_count)
    );

    lenet5_image_feeder #(.TIMEOUT(50)) dut_to (
        .clk(clk), .global_rst(global_rst),
        .i_pix_valid(t_valid), .i_pix_data(t_data), .o_pix_ready(t_ready),
        .o_ce(t_ce), .o_fmap(t_fmap), .o_rst_processEnd(t_rpe),
        .i_cls_en(t_cls_en), .i_cls_result(t_cls_result), .i_cls_end(t_cls_end),
        .o_result(t_result), .o_result_valid(t_rv), .o_timeout(t_to),
        .o_busy(t_busy), .o_img_count(t_cnt)
    );

    logic [7:0] fmap_q[$];
    logic [7:0] exp_q[$];
    logic [3:0] res_q[$];
    int ce_start_q[$];
    int ce_len_q[$];
    int flush_q[$];
    int res_cyc_q[$];
    int end_q[$];
    int acc_last_q[$];
    int stall_start_q[$];
    int stall_end_q[$];
    int tmo_cnt = 0;
    int run_len = 0;
    logic prev_ce = 1'b0;
    logic stalled = 1'b0;

    always @(negedge clk) begin
        if (o_ce) begin
            if (!prev_ce) begin
                ce_start_q.push_back(cyc);
                run_len = 0;
            end
            run_len++;
            fmap_q.push_back(o_fmap);
        end else if (prev_ce) begin
            ce_len_q.push_back(run_len);
        end
        prev_ce = o_ce;
        if (o_rst_processEnd) flush_q.push_back(cyc);
        if (o_result_valid) begin
            res_q.push_back(o_result);
            res_cyc_q.push_back(cyc);
        end
        if (o_timeout) tmo_cnt++;
    end

    task automatic mon_clear();
        fmap_q.delete(); exp_q.delete(); res_q.delete(); ce_start_q.delete();
        ce_len_q.delete(); flush_q.delete(); res_cyc_q.delete(); end_q.delete();
        acc_last_q.delete(); stall_start_q.delete(); stall_end_q.delete();
        tmo_cnt = 0;
        stalled = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int fmap_mismatches();
        int bad;
        bad = 0;
        if (fmap_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (fmap_q[i] !== exp_q[i]) bad++;
        return bad;
    endfunction

    // Pixel idx carries data idx*mult+off; valid is raised with probability duty%.
    task automatic load_pixels(input int count, input int duty, input int mult, input int off);
        int idx;
        int budget;
        idx = 0;
        budget = 0;
        while (idx < count) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 40000) begin
                errors++; checks++;
                $display("FAIL load_budget accepted=%0d required=%0d", idx, count);
                break;
            end
            i_pix_valid = ($urandom_range(99) < duty);
            i_pix_data = 8'(idx * mult + off);
            if (!o_pix_ready && !stalled) begin
                stall_start_q.push_back(cyc);
                stalled = 1'b1;
            end else if (o_pix_ready && stalled) begin
                stall_end_q.push_back(cyc);
                stalled = 1'b0;
            end
            if (i_pix_valid && o_pix_ready) begin
                exp_q.push_back(i_pix_data);
                if (idx % N == N - 1) acc_last_q.push_back(cyc);
                idx++;
            end
        end
        @(posedge clk); #1;
        i_pix_valid = 1'b0;
    endtask

    // Network model: after each burst ends, wait `delay` cycles, then assert
    // i_cls_en and i_cls_end together for one cycle with result base+i.
    task automatic net_model(input int n_img, input int delay, input logic [3:0] base);
        int w;
        for (int i = 0; i < n_img; i++) begin
            w = 0;
            while (!o_ce && w < 20000) begin @(posedge clk); #1; w++; end
            while (o_ce && w < 20000) begin @(posedge clk); #1; w++; end
            if (w >= 20000) begin
                errors++; checks++;
                $display("FAIL net_burst_wait image=%0d waited=%0d limit=20000", i, w);
                return;
            end
            wait_cycles(delay);
            i_cls_en = 1'b1;
            i_cls_end = 1'b1;
            i_cls_result = 4'(base + 4'(i));
            end_q.push_back(cyc);
            @(posedge clk); #1;
            i_cls_en = 1'b0;
            i_cls_end = 1'b0;
        end
    endtask

    task automatic test_reset();
        global_rst = 1'b1;
        wait_cycles(3);
        checks++; if (o_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%0b exp=0", o_ce); end
        checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_pix_ready); end
        checks++;
        if ({o_fmap, o_result, o_rst_processEnd, o_result_valid, o_timeout, o_busy, o_img_count} !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs fmap=%0d result=%0d rpe=%0b rv=%0b to=%0b busy=%0b cnt=%0d exp=all_zero",
                     o_fmap, o_result, o_rst_processEnd, o_result_valid, o_timeout, o_busy, o_img_count);
        end
        global_rst = 1'b0;
        wait_cycles(2);
        checks++;
        if (o_pix_ready !== 1'b1 || o_busy !== 1'b0 || t_ready !== 1'b1 || t_ce !== 1'b0) begin
            errors++;
            $display("FAIL post_reset ready=%0b busy=%0b t_ready=%0b t_ce=%0b exp=1,0,1,0",
                     o_pix_ready, o_busy, t_ready, t_ce);
        end
    endtask

    task automatic test_single_image();
        mon_clear();
        fork
            load_pixels(N, 100, 1, 0);
            net_model(1, 100, 4'd7);
        join
        wait_cycles(5);
        checks++;
        if (ce_len_q.size() != 1 || ce_len_q[0] != N) begin
            errors++; $display("FAIL single_ce_len bursts=%0d len=%0d exp=1,784", ce_len_q.size(),
                               ce_len_q.size() > 0 ? ce_len_q[0] : -1);
        end
        checks++;
        if (ce_start_q.size() != 1 || acc_last_q.size() != 1 || ce_start_q[0] != acc_last_q[0] + 3) begin
            errors++; $display("FAIL single_latency start=%0d exp=%0d", ce_start_q.size() > 0 ? ce_start_q[0] : -1,
                               acc_last_q.size() > 0 ? acc_last_q[0] + 3 : -1);
        end
        checks++; if (fmap_mismatches() != 0) begin errors++; $display("FAIL single_fmap mismatches=%0d exp=0", fmap_mismatches()); end
        checks++; if (o_fmap !== 8'd15) begin errors++; $display("FAIL single_fmap_hold got=%0d exp=15", o_fmap); end
        checks++;
        if (flush_q.size() != 1 || end_q.size() != 1 || flush_q[0] != end_q[0] + 1) begin
            errors++; $display("FAIL single_flush pulses=%0d at=%0d exp=1 at %0d", flush_q.size(),
                               flush_q.size() > 0 ? flush_q[0] : -1, end_q.size() > 0 ? end_q[0] + 1 : -1);
        end
        checks++;
        if (res_q.size() != 1 || res_q[0] !== 4'd7 || res_cyc_q[0] != end_q[0] + 1) begin
            errors++; $display("FAIL single_result count=%0d val=%0d exp=1,7", res_q.size(),
                               res_q.size() > 0 ? res_q[0] : 4'd0);
        end
        checks++; if (o_img_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", o_img_count); end
        checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL single_timeout got=%0d exp=0", tmo_cnt); end
    endtask

    task automatic test_back_to_back();
        mon_clear();
        fork
            load_pixels(3 * N, 100, 1, 0);
            net_model(3, 2000, 4'd2);
        join
        wait_cycles(5);
        checks++;
        if (stall_start_q.size() != 1 || acc_last_q.size() != 3 || stall_start_q[0] != acc_last_q[1] + 1) begin
            errors++; $display("FAIL pp_ready_drop stalls=%0d at=%0d exp=1 at %0d", stall_start_q.size(),
                               stall_start_q.size() > 0 ? stall_start_q[0] : -1,
                               acc_last_q.size() > 1 ? acc_last_q[1] + 1 : -1);
        end
        checks++;
        if (stall_end_q.size() != 1 || flush_q.size() != 3 || stall_end_q[0] != flush_q[0] + 1) begin
            errors++; $display("FAIL pp_ready_rise at=%0d exp=%0d", stall_end_q.size() > 0 ? stall_end_q[0] : -1,
                               flush_q.size() > 0 ? flush_q[0] + 1 : -1);
        end
        checks++;
        if (res_q.size() != 3 || res_q[0] !== 4'd2 || res_q[1] !== 4'd3 || res_q[2] !== 4'd4) begin
            errors++; $display("FAIL pp_results count=%0d exp=3 results 2,3,4", res_q.size());
        end
        checks++;
        if (ce_start_q.size() != 3 || flush_q.size() != 3 || ce_start_q[1] != flush_q[0] + 3 || ce_start_q[2] != flush_q[1] + 3) begin
            errors++; $display("FAIL pp_next_burst bursts=%0d exp=3, each starting 3 cycles after a flush", ce_start_q.size());
        end
        checks++;
        if (ce_len_q.size() != 3 || ce_len_q[0] != N || ce_len_q[1] != N || ce_len_q[2] != N) begin
            errors++; $display("FAIL pp_ce_len bursts=%0d exp=3 of 784", ce_len_q.size());
        end
        checks++; if (fmap_mismatches() != 0) begin errors++; $display("FAIL pp_fmap mismatches=%0d exp=0", fmap_mismatches()); end
        checks++; if (o_img_count !== 16'd4) begin errors++; $display("FAIL pp_count got=%0d exp=4", o_img_count); end
    endtask

    task automatic test_throttle();
        mon_clear();
        fork
            load_pixels(N, 30, 7, 3);
            net_model(1, 10, 4'd9);
        join
        wait_cycles(5);
        checks++;
        if (ce_len_q.size() != 1 || ce_len_q[0] != N) begin
            errors++; $display("FAIL thr_ce_len bursts=%0d exp=1 of 784", ce_len_q.size());
        end
        checks++;
        if (ce_start_q.size() != 1 || acc_last_q.size() != 1 || ce_start_q[0] != acc_last_q[0] + 3) begin
            errors++; $display("FAIL thr_latency start=%0d exp=%0d", ce_start_q.size() > 0 ? ce_start_q[0] : -1,
                               acc_last_q.size() > 0 ? acc_last_q[0] + 3 : -1);
        end
        checks++; if (fmap_mismatches() != 0) begin errors++; $display("FAIL thr_fmap mismatches=%0d exp=0", fmap_mismatches()); end
        checks++;
        if (res_q.size() != 1 || res_q[0] !== 4'd9 || o_img_count !== 16'd5) begin
            errors++; $display("FAIL thr_result count=%0d cnt=%0d exp=1 result 9, cnt 5", res_q.size(), o_img_count);
        end
    endtask

    task automatic test_timeout();
        int last_ce, to_cyc, rpe_cyc, to_n, rv_n, ce_n, nr, w;
        last_ce = -1; to_cyc = -1; rpe_cyc = -1; to_n = 0; rv_n = 0; ce_n = 0; nr = 0; w = 0;
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            t_valid = 1'b1;
            t_data = 8'(i * 3);
            if (!t_ready) nr++;
        end
        @(posedge clk); #1;
        t_valid = 1'b0;
        while (w < 3000 && !(rpe_cyc >= 0 && cyc > rpe_cyc + 5)) begin
            if (t_ce) begin ce_n++; last_ce = cyc; end
            if (t_to) begin to_n++; to_cyc = cyc; end
            if (t_rpe) rpe_cyc = cyc;
            if (t_rv) rv_n++;
            @(posedge clk); #1;
            w++;
        end
        checks++; if (nr != 0 || ce_n != N) begin errors++; $display("FAIL to_burst stalls=%0d ce=%0d exp=0,784", nr, ce_n); end
        checks++;
        if (to_n != 1 || to_cyc != last_ce + 50) begin
            errors++; $display("FAIL to_pulse pulses=%0d at=%0d exp=1 at %0d", to_n, to_cyc, last_ce + 50);
        end
        checks++; if (rpe_cyc < 0 || rpe_cyc != to_cyc + 1) begin errors++; $display("FAIL to_flush at=%0d exp=%0d", rpe_cyc, to_cyc + 1); end
        checks++; if (rv_n != 0) begin errors++; $display("FAIL to_result_valid got=%0d exp=0", rv_n); end
        checks++;
        if (t_cnt !== 16'd1 || t_busy !== 1'b0 || t_fmap !== 8'd45) begin
            errors++; $display("FAIL to_final cnt=%0d busy=%0b fmap=%0d exp=1,0,45", t_cnt, t_busy, t_fmap);
        end
    endtask

    task automatic test_reset_mid_burst();
        int w;
        mon_clear();
        load_pixels(N + 100, 100, 1, 0);
        w = 0;
        while (fmap_q.size() < 300 && w < 5000) begin @(posedge clk); #1; w++; end
        checks++;
        if (o_ce !== 1'b1 || o_fmap !== 8'd44) begin
            errors++; $display("FAIL rm_pixel300 ce=%0b fmap=%0d exp=1,44", o_ce, o_fmap);
        end
        #2 global_rst = 1'b1;
        #1;
        checks++;
        if (o_ce !== 1'b0 || o_busy !== 1'b0 || o_pix_ready !== 1'b1) begin
            errors++; $display("FAIL rm_async ce=%0b busy=%0b ready=%0b exp=0,0,1", o_ce, o_busy, o_pix_ready);
        end
        repeat (3) @(posedge clk);
        #1 global_rst = 1'b0;
        mon_clear();
        checks++;
        if (o_img_count !== 16'd0 || o_pix_ready !== 1'b1) begin
            errors++; $display("FAIL rm_after cnt=%0d ready=%0b exp=0,1", o_img_count, o_pix_ready);
        end
        wait_cycles(20);
        checks++;
        if (ce_start_q.size() != 0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rm_banks_empty bursts=%0d busy=%0b exp=0,0", ce_start_q.size(), o_busy);
        end
        fork
            load_pixels(N, 100, 1, 0);
            net_model(1, 50, 4'd11);
        join
        wait_cycles(5);
        checks++;
        if (ce_start_q.size() != 1 || acc_last_q.size() != 1 || ce_start_q[0] != acc_last_q[0] + 3) begin
            errors++; $display("FAIL rm_fresh_latency bursts=%0d exp=1 starting 3 cycles after last pixel", ce_start_q.size());
        end
        checks++; if (fmap_mismatches() != 0) begin errors++; $display("FAIL rm_fresh_fmap mismatches=%0d exp=0", fmap_mismatches()); end
        checks++;
        if (res_q.size() != 1 || res_q[0] !== 4'd11 || o_img_count !== 16'd1) begin
            errors++; $display("FAIL rm_fresh_result count=%0d cnt=%0d exp=1 result 11, cnt 1", res_q.size(), o_img_count);
        end
    endtask

    task automatic test_stray_end();
        mon_clear();
        i_cls_end = 1'b1;
        @(posedge clk); #1;
        i_cls_end = 1'b0;
        wait_cycles(10);
        checks++;
        if (flush_q.size() != 0 || res_q.size() != 0) begin
            errors++; $display("FAIL stray_flush flushes=%0d valids=%0d exp=0,0", flush_q.size(), res_q.size());
        end
        checks++;
        if (o_img_count !== 16'd1 || o_busy !== 1'b0 || o_result !== 4'd11) begin
            errors++; $display("FAIL stray_state cnt=%0d busy=%0b result=%0d exp=1,0,11", o_img_count, o_busy, o_result);
        end
    endtask

    initial begin
        global_rst = 1'b1;
        i_pix_valid = 1'b0; i_pix_data = 8'd0;
        i_cls_en = 1'b0; i_cls_result = 4'd0; i_cls_end = 1'b0;
        t_valid = 1'b0; t_data = 8'd0;
        t_cls_en = 1'b0; t_cls_result = 4'd0; t_cls_end = 1'b0;
        test_reset();
        test_single_image();
        test_back_to_back();
        test_throttle();
        test_timeout();
        test_reset_mid_burst();
        test_stray_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_watchdog time=%0t limit=900000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
